// File: rtl/tpuv1_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : tpuv1_host_seq
// Summary  : Bus initiator that loads A/B/C into a tpuv1, starts the multiply,
//            waits it out and streams the C matrix back on a valid/ready port.
// Revision : 1.0
// ============================================================================
module tpuv1_host_seq #(
    parameter int DIM         = 8,
    parameter int BITS_AB     = 8,
    parameter int BITS_C      = 16,
    parameter int ADDRW       = 16,
    parameter int DATAW       = 64,
    parameter int WAIT_CYCLES = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear_c,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             r_w,
    output logic [ADDRW-1:0] addr,
    output logic [DATAW-1:0] dataIn,
    input  logic [DATAW-1:0] dataOut
);

    localparam int c_CNTW  = $clog2(2*DIM) + 1;
    localparam int c_WAITW = $clog2(WAIT_CYCLES) + 1;

    localparam logic [ADDRW-1:0] c_BASE_A    = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] c_BASE_B    = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] c_BASE_C    = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] c_ADDR_STRT = ADDRW'(16'h0400);

    generate
        if (DATAW != DIM*BITS_AB || DATAW != 4*BITS_C || WAIT_CYCLES < 3*DIM-1) begin : g_param_check
            $error("tpuv1_host_seq: inconsistent parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_LOAD_C = 3'd3,
        S_START  = 3'd4,
        S_WAIT   = 3'd5,
        S_READ_C = 3'd6,
        S_DRAIN  = 3'd7
    } state_t;

    state_t              r_state, w_state;
    logic                r_clr, w_clr;
    logic [c_CNTW-1:0]   r_cnt, w_cnt;
    logic [c_WAITW-1:0]  r_wait, w_wait;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_out_valid, w_out_valid;
    logic [DATAW-1:0]    r_out_data, w_out_data;
    logic                r_rw, w_rw;
    logic [ADDRW-1:0]    r_addr, w_addr;
    logic [DATAW-1:0]    r_din, w_din;

    logic                w_accept;
    logic                w_slot_free;
    logic [c_CNTW-1:0]   w_cnt_inc;

    // Rows/half-rows are one bus word apart, i.e. 8 bytes.
    function automatic logic [ADDRW-1:0] f_word_addr(input logic [ADDRW-1:0] base,
                                                     input logic [c_CNTW-1:0] idx);
        return base + ADDRW'({idx, 3'b000});
    endfunction

    assign in_ready    = (r_state == S_LOAD_A) || (r_state == S_LOAD_B) ||
                         ((r_state == S_LOAD_C) && !r_clr);
    assign w_accept    = in_valid && in_ready;
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_cnt_inc   = r_cnt + c_CNTW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_clr       <= 1'b0;
            r_cnt       <= '0;
            r_wait      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
        end else begin
            r_state     <= w_state;
            r_clr       <= w_clr;
            r_cnt       <= w_cnt;
            r_wait      <= w_wait;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_out_valid <= w_out_valid;
            r_out_data  <= w_out_data;
            r_rw        <= w_rw;
            r_addr      <= w_addr;
            r_din       <= w_din;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_clr       = r_clr;
        w_cnt       = r_cnt;
        w_wait      = r_wait;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_out_valid = r_out_valid;
        w_out_data  = r_out_data;
        w_rw        = 1'b0;
        w_addr      = '0;
        w_din       = '0;

        if (r_out_valid && out_ready) begin
            w_out_valid = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clr   = clear_c;
                    w_busy  = 1'b1;
                    w_cnt   = '0;
                    w_state = S_LOAD_A;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (w_accept) begin
                    w_rw   = 1'b1;
                    w_addr = f_word_addr((r_state == S_LOAD_A) ? c_BASE_A : c_BASE_B, r_cnt);
                    w_din  = in_data;
                    if (r_cnt == c_CNTW'(DIM-1)) begin
                        w_cnt   = '0;
                        w_state = (r_state == S_LOAD_A) ? S_LOAD_B : S_LOAD_C;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
            end
            S_LOAD_C: begin
                // With clear_c the zero fill runs unthrottled, one word per cycle.
                if (r_clr || w_accept) begin
                    w_rw   = 1'b1;
                    w_addr = f_word_addr(c_BASE_C, r_cnt);
                    w_din  = r_clr ? '0 : in_data;
                    if (r_cnt == c_CNTW'(2*DIM-1)) begin
                        w_cnt   = '0;
                        w_state = S_START;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
            end
            S_START: begin
                w_rw    = 1'b1;
                w_addr  = c_ADDR_STRT;
                w_wait  = c_WAITW'(WAIT_CYCLES);
                w_state = S_WAIT;
            end
            S_WAIT: begin
                // First WAIT cycle carries the start write; WAIT_CYCLES idle cycles follow.
                if (r_wait == '0) begin
                    w_addr  = c_BASE_C;
                    w_state = S_READ_C;
                end else begin
                    w_wait = r_wait - c_WAITW'(1);
                end
            end
            S_READ_C: begin
                w_addr = f_word_addr(c_BASE_C, r_cnt);
                if (w_slot_free) begin
                    w_out_data  = dataOut;
                    w_out_valid = 1'b1;
                    if (r_cnt == c_CNTW'(2*DIM-1)) begin
                        w_cnt   = '0;
                        w_addr  = '0;
                        w_state = S_DRAIN;
                    end else begin
                        w_cnt  = w_cnt_inc;
                        w_addr = f_word_addr(c_BASE_C, w_cnt_inc);
                    end
                end
            end
            S_DRAIN: begin
                if (r_out_valid && out_ready) begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign r_w       = r_rw;
    assign addr      = r_addr;
    assign dataIn    = r_din;

endmodule
`default_nettype wire

// File: tb/tb_tpuv1_host_seq.sv
`default_nettype none
// Bench for tpuv1_host_seq: tpuv1 slave model, randomized jobs, scoreboarded
// bus trace and result stream checked against a matrix-level reference.
module tb_tpuv1_host_seq;
    localparam int DIM         = 8;
    localparam int WAIT_CYCLES = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear_c = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic        busy, done, in_ready, out_valid, r_w;
    logic [63:0] out_data, dataIn, dataOut;
    logic [15:0] addr;

    always #5 clk = ~clk;

    tpuv1_host_seq #(.DIM(DIM), .BITS_AB(8), .BITS_C(16), .ADDRW(16), .DATAW(64),
                     .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear_c(clear_c),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .r_w(r_w), .addr(addr), .dataIn(dataIn), .dataOut(dataOut)
    );

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [63:0] data;
        logic        chkd;
    } bus_t;

    bus_t        bus_q[$];
    logic [63:0] src_q[$];
    logic [63:0] out_q[$];

    int n_cmp = 0, n_bad = 0;
    int cfg_gap = 0, cfg_rdy = 100;
    bit cfg_stall = 0;
    int stall_left = 0;
    int acc_cnt = 0, hand_cnt = 0, done_cnt = 0;
    bit seen_b4 = 0, in_wait = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- tpuv1 slave model ----------------
    logic [63:0] amem[DIM];
    logic [63:0] bmem[DIM];
    logic [63:0] cmem[2*DIM];

    always @(posedge clk) begin
        if (r_w) begin
            if (addr[15:8] == 8'h01 && addr[7:6] == 2'b00) amem[addr[5:3]] = dataIn;
            else if (addr[15:8] == 8'h02 && addr[7:6] == 2'b00) bmem[addr[5:3]] = dataIn;
            else if (addr[15:8] == 8'h03 && addr[7] == 1'b0) cmem[addr[6:3]] = dataIn;
            else if (addr == 16'h0400) begin
                for (int i = 0; i < DIM; i++) begin
                    for (int j = 0; j < DIM; j++) begin
                        int acc;
                        acc = int'(cmem[2*i + j/4][16*(j%4) +: 16]);
                        for (int k = 0; k < DIM; k++)
                            acc += int'(amem[i][8*k +: 8]) * int'(bmem[k][8*j +: 8]);
                        cmem[2*i + j/4][16*(j%4) +: 16] = 16'(acc);
                    end
                end
            end
        end
    end

    always_comb begin
        dataOut = '0;
        if (!r_w && addr[15:8] == 8'h03 && addr[7] == 1'b0) dataOut = cmem[addr[6:3]];
    end

    // ---------------- operand source ----------------
    initial begin : drv
        bit hs;
        logic [63:0] tmp;
        forever begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0) begin
                tmp = src_q.pop_front();
                acc_cnt++;
            end
            if (src_q.size() > 0 && $urandom_range(0, 99) >= cfg_gap) begin
                in_valid = 1'b1;
                in_data  = src_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
            end
        end
    end

    // ---------------- result consumer ----------------
    initial begin : cons
        forever begin
            @(posedge clk);
            #1;
            if (cfg_stall && hand_cnt == 3 && stall_left > 0) begin
                out_ready  = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 99) < cfg_rdy);
            end
        end
    end

    // ---------------- bus trace monitor ----------------
    int          idle_cnt = 0;
    bit          last_rd = 0;
    logic [15:0] last_addr = '0;

    task automatic bus_pop();
        bus_t t;
        if (bus_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bus_unexpected: got rw=%0d addr=%h expected no transaction", r_w, addr);
        end else begin
            t = bus_q.pop_front();
            chk("bus_rw", 64'(r_w), 64'(t.rw));
            chk("bus_addr", 64'(addr), 64'(t.addr));
            if (t.chkd) chk("bus_wdata", dataIn, t.data);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_wait  = 0;
            idle_cnt = 0;
            last_rd  = 0;
        end else if (r_w) begin
            bus_pop();
            if (addr == 16'h0400) begin
                in_wait  = 1;
                idle_cnt = 0;
            end
            if (addr == 16'h0220) seen_b4 = 1;
            last_rd = 0;
        end else if (addr != 16'h0000) begin
            if (!last_rd || addr != last_addr) begin
                if (in_wait) begin
                    chk("wait_idle_cycles", 64'(idle_cnt), 64'(WAIT_CYCLES));
                    in_wait = 0;
                end
                bus_pop();
            end
            last_rd   = 1;
            last_addr = addr;
        end else begin
            chk("idle_dataIn", dataIn, 64'h0);
            if (in_wait) idle_cnt++;
            last_rd = 0;
        end
    end

    // ---------------- result monitor ----------------
    bit          prev_hold = 0;
    logic [63:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("out_valid_held", 64'(out_valid), 64'h1);
                chk("out_data_stable", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_unexpected: got %h expected no word", out_data);
                end else begin
                    chk("out_word", out_data, out_q.pop_front());
                end
                hand_cnt++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", 64'(busy), 64'h0);
                chk("results_all_out_at_done", 64'(out_q.size()), 64'h0);
            end
        end
    end

    // ---------------- reference model / job control ----------------
    int job_words = 0;

    task automatic prep_job(input int kind, input bit clr);
        int a[DIM][DIM];
        int b[DIM][DIM];
        int c[DIM][DIM];
        int r;
        logic [63:0] w;
        done_cnt = 0; acc_cnt = 0; hand_cnt = 0; stall_left = 5; seen_b4 = 0;
        for (int i = 0; i < DIM; i++) begin
            for (int k = 0; k < DIM; k++) begin
                a[i][k] = (kind == 0) ? ((i == k) ? 1 : 0) : int'($urandom_range(0, 255));
                b[i][k] = (kind == 0) ? i + 1 : int'($urandom_range(0, 255));
                c[i][k] = clr ? 0 : ((kind == 0) ? 1 : int'($urandom_range(0, 65535)));
            end
        end
        for (int i = 0; i < DIM; i++) begin
            w = '0;
            for (int k = 0; k < DIM; k++) w[8*k +: 8] = 8'(a[i][k]);
            src_q.push_back(w);
            bus_q.push_back('{1'b1, 16'(256 + 8*i), w, 1'b1});
        end
        for (int i = 0; i < DIM; i++) begin
            w = '0;
            for (int k = 0; k < DIM; k++) w[8*k +: 8] = 8'(b[i][k]);
            src_q.push_back(w);
            bus_q.push_back('{1'b1, 16'(512 + 8*i), w, 1'b1});
        end
        for (int j = 0; j < 2*DIM; j++) begin
            w = '0;
            for (int e = 0; e < 4; e++) w[16*e +: 16] = 16'(c[j/2][4*(j%2) + e]);
            if (!clr) src_q.push_back(w);
            bus_q.push_back('{1'b1, 16'(768 + 8*j), clr ? 64'h0 : w, 1'b1});
        end
        bus_q.push_back('{1'b1, 16'h0400, 64'h0, 1'b1});
        for (int j = 0; j < 2*DIM; j++) begin
            bus_q.push_back('{1'b0, 16'(768 + 8*j), 64'h0, 1'b0});
            w = '0;
            for (int e = 0; e < 4; e++) begin
                r = c[j/2][4*(j%2) + e];
                for (int k = 0; k < DIM; k++) r += a[j/2][k] * b[k][4*(j%2) + e];
                w[16*e +: 16] = 16'(r);
            end
            out_q.push_back(w);
        end
        job_words = clr ? 2*DIM : 4*DIM;
    endtask

    task automatic kick(input bit clr);
        @(posedge clk); #1;
        start = 1'b1; clear_c = clr;
        @(posedge clk); #1;
        start = 1'b0; clear_c = 1'($urandom_range(0, 1));
        chk("busy_after_start", 64'(busy), 64'h1);
    endtask

    task automatic poke_start_in_wait();
        int t = 0;
        while (!in_wait && t < 500) begin @(negedge clk); t++; end
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_job();
        int t = 0;
        while (done_cnt == 0 && t < 4000) begin @(negedge clk); t++; end
        if (done_cnt == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL job_timeout: got no done after %0d cycles expected done", t);
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", 64'(done_cnt), 64'h1);
        chk("words_consumed", 64'(acc_cnt), 64'(job_words));
        chk("src_left", 64'(src_q.size()), 64'h0);
        chk("bus_left", 64'(bus_q.size()), 64'h0);
        chk("out_left", 64'(out_q.size()), 64'h0);
        chk("handoffs", 64'(hand_cnt), 64'(2*DIM));
        chk("busy_idle", 64'(busy), 64'h0);
    endtask

    task automatic run_job(input int kind, input bit clr, input int gap, input int rdy,
                           input bit stall, input bit poke);
        cfg_gap = gap; cfg_rdy = rdy; cfg_stall = stall;
        prep_job(kind, clr);
        kick(clr);
        if (poke) poke_start_in_wait();
        finish_job();
        cfg_stall = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin : main
        int t;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_bus", {47'h0, r_w, addr}, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_job(0, 1'b1, 0, 100, 1'b0, 1'b0);
        run_job(0, 1'b0, 0, 100, 1'b0, 1'b0);
        run_job(1, 1'b0, 40, 100, 1'b0, 1'b0);
        run_job(1, 1'b1, 0, 100, 1'b1, 1'b0);
        run_job(1, 1'b0, 20, 60, 1'b0, 1'b1);

        // Abort in the middle of LOAD_B.
        cfg_gap = 0; cfg_rdy = 100;
        prep_job(1, 1'b0);
        kick(1'b0);
        t = 0;
        while (!seen_b4 && t < 500) begin @(negedge clk); t++; end
        if (!seen_b4) begin
            n_cmp++;
            n_bad++;
            $display("FAIL abort_reach_b4: got no write to 0220 expected one");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_in_ready", 64'(in_ready), 64'h0);
        chk("abort_outs", {62'h0, out_valid, done}, 64'h0);
        chk("abort_out_data", out_data, 64'h0);
        chk("abort_bus", {47'h0, r_w, addr}, 64'h0);
        chk("abort_dataIn", dataIn, 64'h0);
        src_q.delete(); bus_q.delete(); out_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_abort_idle", {46'h0, busy, in_ready, addr}, 64'h0);

        run_job(1, 1'b0, 30, 70, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++)
            run_job(1, 1'($urandom_range(0, 1)), $urandom_range(0, 50), $urandom_range(40, 100),
                    1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
